// File: rtl/mem_scheme_pkg.sv
// Shared types and helpers for the banked memory controller.
// Holds FSM encoding, bank decode, parity and default widths.
package mem_scheme_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_BANK_BITS = 2;

  localparam int IDX_W      = 5;
  localparam int MAX_BANKS  = 2 ** IDX_W;
  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  function automatic logic [MAX_BANKS-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    return MAX_BANKS'(1) << idx;
  endfunction

  function automatic logic even_parity(
    input logic [MAX_DATA_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/memory_bank.sv
// Single-port synchronous RAM with registered read.
// Contents are deliberately not reset.
module memory_bank #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/banked_memory_ctrl.sv
// Valid/ready front end over NUM_BANKS synchronous banks.
// Define MEM_PARITY_EN to store even parity and flag read errors.
module banked_memory_ctrl
  import mem_scheme_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BANK_BITS = DEF_BANK_BITS
) (
  input  logic                    m_clk,
  input  logic                    m_rst_n,
  input  logic                    m_req_valid,
  output logic                    m_req_ready,
  input  logic                    m_req_write,
  input  logic [ADDR_W-1:0]       m_req_addr,
  input  logic [DATA_W-1:0]       m_req_wdata,
  output logic                    m_rsp_valid,
  output logic [DATA_W-1:0]       m_rsp_rdata,
  output logic [2**BANK_BITS-1:0] m_bank_sel,
`ifdef MEM_PARITY_EN
  output logic                    m_parity_err,
`endif
  output logic                    m_busy
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int LOC_W     = ADDR_W - BANK_BITS;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t state, state_d;

  logic [LOC_W-1:0]     loc_q;
  logic                 wr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [NUM_BANKS-1:0] dec_sel;
  logic                 accept;
  logic [MEM_W-1:0]     bank_wdata;
  logic [MEM_W-1:0]     bank_rdata [NUM_BANKS];
  logic [MEM_W-1:0]     rd_word;

  assign m_req_ready = (state == IDLE);
  assign m_busy      = ~m_req_ready;
  assign accept      = m_req_ready & m_req_valid;

  assign dec_sel = NUM_BANKS'(onehot(
    IDX_W'(m_req_addr[ADDR_W-1 -: BANK_BITS])));

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (m_req_valid) state_d = ACCESS;
      ACCESS:  state_d = wr_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      state       <= IDLE;
      loc_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      m_bank_sel  <= '0;
      m_rsp_valid <= 1'b0;
      m_rsp_rdata <= '0;
    end else begin
      state       <= state_d;
      m_rsp_valid <= 1'b0;
      if (accept) begin
        loc_q      <= m_req_addr[LOC_W-1:0];
        wr_q       <= m_req_write;
        wdata_q    <= m_req_wdata;
        m_bank_sel <= dec_sel;
      end else if (state_d == IDLE) begin
        m_bank_sel <= '0;
      end
      // bank output was registered at the end of ACCESS
      if (state == RESP) begin
        m_rsp_valid <= 1'b1;
        m_rsp_rdata <= rd_word[DATA_W-1:0];
      end
    end
  end

`ifdef MEM_PARITY_EN
  assign bank_wdata = {
    even_parity(MAX_DATA_W'(wdata_q)), wdata_q};

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      m_parity_err <= 1'b0;
    end else begin
      m_parity_err <= (state == RESP) &&
        (even_parity(MAX_DATA_W'(rd_word[DATA_W-1:0]))
         != rd_word[DATA_W]);
    end
  end
`else
  assign bank_wdata = wdata_q;
`endif

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (m_bank_sel[i]) rd_word = rd_word | bank_rdata[i];
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic en;
    assign en = (state == ACCESS) & m_bank_sel[i];

    memory_bank #(
      .WIDTH(MEM_W),
      .AW   (LOC_W)
    ) u_bank (
      .clk  (m_clk),
      .en   (en),
      .we   (en & wr_q),
      .addr (loc_q),
      .wdata(bank_wdata),
      .rdata(bank_rdata[i])
    );
  end

endmodule

// File: doc/banked_memory_ctrl.md
Name: banked_memory_ctrl

Overview:
- Parametrised, clocked successor to the team's 4-group, 256-byte memory scheme.
- Accepts single-word read/write requests over a valid/ready handshake.
- Decodes the top address bits into a one-hot bank select and accesses one of NUM_BANKS synchronous memory banks.
- Returns read data through a registered response port; sits between a bus master (CPU/test sequencer) and the bank array.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, total word-address width.
- BANK_BITS, 2, number of top address bits used for bank decode; NUM_BANKS = 2**BANK_BITS.
- WORDS_PER_BANK, 2**(ADDR_W-BANK_BITS), derived; not overridable.

Ports:
- m_clk  in  1  system clock, rising-edge.
- m_rst_n  in  1  asynchronous active-low reset.
- m_req_valid  in  1  request present.
- m_req_ready  out  1  controller can accept a request.
- m_req_write  in  1  1 = write, 0 = read.
- m_req_addr  in  ADDR_W  word address.
- m_req_wdata  in  DATA_W  write data.
- m_rsp_valid  out  1  read data valid, one-cycle pulse.
- m_rsp_rdata  out  DATA_W  read data.
- m_bank_sel  out  NUM_BANKS  one-hot active-bank indicator.
- m_busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE; m_rsp_valid = 0, m_rsp_rdata = 0, m_bank_sel = 0, m_busy = 0.
  - m_req_ready = 1 (it is IDLE-decoded).
  - Bank contents are NOT reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - m_req_ready = 1.
  - On m_req_valid & m_req_ready at an edge: latch addr, write and wdata; m_bank_sel <= onehot(addr[ADDR_W-1 -: BANK_BITS]); go to ACCESS.
- ACCESS:
  - m_req_ready = 0.
  - The selected bank is enabled with local address addr[ADDR_W-BANK_BITS-1:0].
  - Write: word committed at the end of this cycle; next state IDLE; no response.
  - Read: bank output registered into m_rsp_rdata at the end of this cycle; next state RESP.
- RESP:
  - m_rsp_valid = 1 for exactly one cycle; next state IDLE.
  - m_bank_sel is cleared on return to IDLE.
- Latency:
  - Read accepted at edge N -> m_rsp_valid high in the cycle after edge N+2.
  - Throughput: write 1 per 2 cycles, read 1 per 3 cycles.
- No response backpressure: the master must sample m_rsp_valid.
- m_rsp_rdata holds its last value until the next read.
- m_req_valid while m_req_ready = 0 is ignored; the master holds the request until the handshake completes.
- Read immediately after a write to the same address returns the new data.
- All addresses map to a bank, so there is no out-of-range case; the top bank covers addr = 2**ADDR_W-1.
- Only the selected bank is enabled; the other banks' enables stay low.
- Reset mid-operation: FSM returns to IDLE immediately and no response is issued. A write whose commit edge had not yet occurred is lost; all other stored words are unchanged.

Optional Feature:
- Macro: MEM_PARITY_EN.
- When defined:
  - Each bank word is DATA_W+1 bits; the even-parity bit of wdata is stored on write.
  - On read, parity is recomputed.
  - Extra output m_parity_err (1 bit, reset 0) pulses high together with m_rsp_valid on mismatch.
- When undefined: no parity storage, no m_parity_err port, bank width = DATA_W.

Decomposition:
- Package mem_scheme_pkg holds:
  - FSM state encoding (IDLE/ACCESS/RESP);
  - the bank-decode function onehot(idx) -> NUM_BANKS bits;
  - the even-parity function;
  - default width constants.
- One sub-module: memory_bank, a single-port synchronous RAM of WORDS_PER_BANK x (DATA_W[+1]) with en, we, addr, wdata, rdata (registered read). It is instantiated NUM_BANKS times via generate.

Test Plan:
- Reset: hold m_rst_n = 0 for 3 cycles -> m_req_ready = 1, m_rsp_valid = 0, m_rsp_rdata = 8'h00, m_bank_sel = 4'b0000, m_busy = 0.
- Write/read per bank: write 8'hA5@8'h05, 8'h5A@8'h45, 8'hC3@8'h85, 8'h3C@8'hC5 -> m_bank_sel shows 0001/0010/0100/1000 in ACCESS. Reading each address back gives m_rsp_rdata = written value with m_rsp_valid exactly 2 cycles after acceptance.
- Boundaries: write 8'hFF@8'h3F and 8'h11@8'h40; read both -> 8'hFF (bank 0) and 8'h11 (bank 1), no aliasing. Write/read 8'h77@8'hFF -> 8'h77.
- Handshake: hold m_req_valid = 1 continuously with alternating writes -> m_req_ready toggles 1,0 and exactly one write commits per 2 cycles. A request changed while ready = 0 is not captured.
- Reset mid-read: assert m_rst_n = 0 during ACCESS of a read -> no m_rsp_valid pulse; after release, a prior write 8'hA5@8'h05 still reads 8'hA5.
- MEM_PARITY_EN: force a stored parity bit flip on addr 8'h10 via hierarchical deposit and read -> m_parity_err = 1 coincident with m_rsp_valid. A clean read gives m_parity_err = 0.
